// File: rtl/mult_pkg.sv
// Shared constants and control-state encodings for the
// sequential shift-and-add multiplier.
package mult_pkg;
    localparam int MULT_N = 8;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mult_state_e;
endpackage

// File: rtl/mult_shift_counter.sv
// Mod-N shift counter; terminal count flags the N-th shift.
module mult_shift_counter
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == LAST);
    assign o_tc = w_tc;

    // Wrap explicitly at N-1 so non-power-of-2 widths stay in range
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add datapath executing Load/Ad/Sh commands
// from the multiplier control FSM.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);
    logic [2*N:0] r_acc;
    logic [N-1:0] r_mc;
    logic [N:0]   w_sum;
    logic         w_cnt_en;
    logic         w_tc;

    assign w_sum    = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_mc};
    assign w_cnt_en = Sh & ~Load & ~Ad;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc <= '0;
            r_mc  <= '0;
        end else if (Load) begin
            r_acc <= {{(N + 1){1'b0}}, Mplier};
            r_mc  <= Mcand;
        end else if (Ad) begin
            r_acc[2*N:N] <= w_sum;
        end else if (Sh) begin
            r_acc <= {1'b0, r_acc[2*N:1]};
        end
    end

    mult_shift_counter #(
        .N(N)
    ) u_cnt (
        .i_clk  (Clk),
        .i_rst_n(Rst_n),
        .i_clr  (Load),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    assign M       = r_acc[0];
    assign K       = w_tc;
    assign Product = r_acc[2*N-1:0];
endmodule
